// File: rtl/mor1kx_snoop_pkg.sv
// mor1kx_snoop_pkg: state encodings and tag geometry helpers shared by the snoop responder.
package mor1kx_snoop_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GRANT     = 3'd1;
    localparam logic [2:0] ST_TAG_RD    = 3'd2;
    localparam logic [2:0] ST_DATA_RD   = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;
    localparam logic [2:0] ST_WAIT_DROP = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        GRANT     = ST_GRANT,
        TAG_RD    = ST_TAG_RD,
        DATA_RD   = ST_DATA_RD,
        RESP      = ST_RESP,
        WAIT_DROP = ST_WAIT_DROP
    } snoop_state_e;

    function automatic int tag_width(input int dw, input int bw, input int sw);
        return dw - bw - sw;
    endfunction

    // The valid flag sits directly above the tag bits in a tag RAM word.
    function automatic int tag_valid_bit(input int tw);
        return tw;
    endfunction

endpackage

// File: rtl/mor1kx_snoop_responder.sv
// mor1kx_snoop_responder: answers interconnect snoops by borrowing the data-cache
// RAM ports, returning the cached word on a hit and invalidating that line.
module mor1kx_snoop_responder
    import mor1kx_snoop_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OPTION_DCACHE_BLOCK_WIDTH = 5,
    parameter int OPTION_DCACHE_SET_WIDTH = 9,
    parameter int TAG_WIDTH = tag_width(DATA_WIDTH, OPTION_DCACHE_BLOCK_WIDTH, OPTION_DCACHE_SET_WIDTH)
) (
    input  logic                                                      wb_clk_i,
    input  logic                                                      wb_rst_i,
    input  logic [DATA_WIDTH-1:0]                                     snoop_adr_i,
    input  logic                                                      snoop_req_i,
    output logic                                                      snoop_ack_o,
    output logic                                                      snoop_hit_o,
    output logic [DATA_WIDTH-1:0]                                     snoop_dat_o,
    output logic                                                      cache_req_o,
    input  logic                                                      cache_gnt_i,
    output logic                                                      tag_re_o,
    output logic                                                      tag_we_o,
    output logic [OPTION_DCACHE_SET_WIDTH-1:0]                        tag_adr_o,
    output logic [TAG_WIDTH:0]                                        tag_wdat_o,
    input  logic [TAG_WIDTH:0]                                        tag_dat_i,
    output logic                                                      data_re_o,
    output logic [OPTION_DCACHE_SET_WIDTH+OPTION_DCACHE_BLOCK_WIDTH-3:0] data_adr_o,
    input  logic [DATA_WIDTH-1:0]                                     data_dat_i
);

    localparam int BW = OPTION_DCACHE_BLOCK_WIDTH;
    localparam int SW = OPTION_DCACHE_SET_WIDTH;
    localparam int VB = tag_valid_bit(TAG_WIDTH);

    snoop_state_e              state_q;
    logic [DATA_WIDTH-1:2]     adr_q;
    logic                      ack_q, hit_q, cache_req_q, tag_re_q, tag_we_q, data_re_q;
    logic [DATA_WIDTH-1:0]     dat_q;
    logic [SW-1:0]             tag_adr_q;
    logic [TAG_WIDTH:0]        tag_wdat_q;
    logic [SW+BW-3:0]          data_adr_q;
    logic                      hit_d;
    logic                      unused_lsb;

    // Byte lanes within a word never affect a snoop.
    assign unused_lsb = ^snoop_adr_i[1:0];

    assign hit_d = tag_dat_i[VB] & (tag_dat_i[TAG_WIDTH-1:0] == adr_q[DATA_WIDTH-1:BW+SW]);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            ack_q       <= 1'b0;
            hit_q       <= 1'b0;
            dat_q       <= '0;
            cache_req_q <= 1'b0;
            tag_re_q    <= 1'b0;
            tag_we_q    <= 1'b0;
            data_re_q   <= 1'b0;
            tag_adr_q   <= '0;
            tag_wdat_q  <= '0;
            data_adr_q  <= '0;
        end else begin
            tag_re_q  <= 1'b0;
            tag_we_q  <= 1'b0;
            data_re_q <= 1'b0;
            case (state_q)
                IDLE: if (snoop_req_i) begin
                    adr_q       <= snoop_adr_i[DATA_WIDTH-1:2];
                    cache_req_q <= 1'b1;
                    state_q     <= GRANT;
                end
                GRANT: if (cache_gnt_i) begin
                    tag_re_q  <= 1'b1;
                    tag_adr_q <= adr_q[BW+SW-1:BW];
                    state_q   <= TAG_RD;
                end
                TAG_RD: if (hit_d) begin
                    // Read the word and drop the line in the same cycle.
                    data_re_q  <= 1'b1;
                    tag_we_q   <= 1'b1;
                    data_adr_q <= adr_q[BW+SW-1:2];
                    tag_wdat_q <= {1'b0, adr_q[DATA_WIDTH-1:BW+SW]};
                    state_q    <= DATA_RD;
                end else begin
                    ack_q   <= 1'b1;
                    hit_q   <= 1'b0;
                    dat_q   <= '0;
                    state_q <= RESP;
                end
                DATA_RD: begin
                    ack_q   <= 1'b1;
                    hit_q   <= 1'b1;
                    dat_q   <= data_dat_i;
                    state_q <= RESP;
                end
                RESP: begin
                    ack_q       <= 1'b0;
                    hit_q       <= 1'b0;
                    dat_q       <= '0;
                    cache_req_q <= 1'b0;
                    state_q     <= WAIT_DROP;
                end
                WAIT_DROP: if (!snoop_req_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign snoop_ack_o = ack_q;
    assign snoop_hit_o = hit_q;
    assign snoop_dat_o = dat_q;
    assign cache_req_o = cache_req_q;
    assign tag_re_o    = tag_re_q;
    assign tag_we_o    = tag_we_q;
    assign tag_adr_o   = tag_adr_q;
    assign tag_wdat_o  = tag_wdat_q;
    assign data_re_o   = data_re_q;
    assign data_adr_o  = data_adr_q;

endmodule
